activation_sequencer: RTL and testbench

//  Job-level controller for the activation stage. Accepts one layer descriptor per job:

---
 rtl/act_pkg.sv | 21 ++
 rtl/act_seq_pipe.sv | 38 +++
 rtl/activation_sequencer.sv | 154 +++++++++++++++
 tb/tb_activation_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - shared enums and default widths for the activation stage
package act_pkg;

   localparam int ACT_ADDR_WIDTH    = 8;
   localparam int ACT_ROW_CNT_WIDTH = 9;

   typedef enum logic [1:0] {
      ACT_RELU    = 2'd0,
      ACT_SIGMOID = 2'd1,
      ACT_TANH    = 2'd2,
      ACT_BYPASS  = 2'd3
   } act_sel_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } act_seq_state_e;

endpackage

// File: rtl/act_seq_pipe.sv
// rtl/act_seq_pipe.sv - read/activate/write pipeline valids, advance and written counter
module act_seq_pipe import act_pkg::*; #(
   parameter int ROW_CNT_WIDTH = ACT_ROW_CNT_WIDTH
) (
   input  logic                     clk,
   input  logic                     async_rst,
   input  logic                     flush,
   input  logic                     issue,
   input  logic                     wr_ready,
   output logic                     advance,
   output logic                     s1_valid,
   output logic                     s2_valid,
   output logic [ROW_CNT_WIDTH-1:0] written
);

   // A full output stage that the buffer refuses freezes the whole pipe.
   assign advance = !s2_valid | wr_ready;

   always_ff @(posedge clk or negedge async_rst) begin
      if (!async_rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         written  <= '0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         written  <= '0;
      end else begin
         if (advance) begin
            s1_valid <= issue;
            s2_valid <= s1_valid;
         end
         if (s2_valid && wr_ready)
            written <= written + 1'b1;
      end
   end

endmodule

// File: rtl/activation_sequencer.sv
// rtl/activation_sequencer.sv - job controller for the activation stage
// ACT_SEQ_PERF_EN adds the stall_cycles/job_cycles counters.
module activation_sequencer import act_pkg::*; #(
   parameter int ADDR_WIDTH    = ACT_ADDR_WIDTH,
   parameter int ROW_CNT_WIDTH = ACT_ROW_CNT_WIDTH
) (
   input  logic                     clk,
   input  logic                     async_rst,
   input  logic                     abort,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [1:0]               cfg_sel,
   input  logic [ROW_CNT_WIDTH-1:0] cfg_rows,
   input  logic [ADDR_WIDTH-1:0]    cfg_src_base,
   input  logic [ADDR_WIDTH-1:0]    cfg_dst_base,
   output logic                     rd_en,
   output logic [ADDR_WIDTH-1:0]    rd_addr,
   output logic                     act_en,
   output logic                     act_sync_rst,
   output logic [1:0]               act_sel,
   output logic                     wr_en,
   output logic [ADDR_WIDTH-1:0]    wr_addr,
   input  logic                     wr_ready,
   output logic                     busy,
   output logic                     done
`ifdef ACT_SEQ_PERF_EN
   ,
   output logic [31:0]              stall_cycles,
   output logic [31:0]              job_cycles
`endif
);

   act_seq_state_e           state;
   act_sel_e                 sel_q;
   logic [ROW_CNT_WIDTH-1:0] rows_q;
   logic [ROW_CNT_WIDTH-1:0] issued;
   logic [ROW_CNT_WIDTH-1:0] written;
   logic [ADDR_WIDTH-1:0]    src_q;
   logic [ADDR_WIDTH-1:0]    dst_q;
   logic                     advance;
   logic                     s1_valid;
   logic                     s2_valid;
   logic                     cfg_accept;
   logic                     abort_hit;
   logic                     last_write;

   assign cfg_accept = cfg_valid & cfg_ready;
   assign abort_hit  = abort & (state != IDLE);
   assign act_sel    = sel_q;

   assign rd_en   = (state == RUN) & advance & (issued < rows_q);
   assign rd_addr = src_q + ADDR_WIDTH'(issued);
   // CLEAR strobes en together with sync_rst so the unit's output regs load zero.
   assign act_en  = (state == CLEAR) | (s1_valid & advance);
   assign wr_en   = s2_valid;
   assign wr_addr = dst_q + ADDR_WIDTH'(written);

   assign last_write = (state == DRAIN) & s2_valid & wr_ready & (written == rows_q - 1'b1);

   act_seq_pipe #(
      .ROW_CNT_WIDTH (ROW_CNT_WIDTH)
   ) u_pipe (
      .clk       (clk),
      .async_rst (async_rst),
      .flush     (abort_hit | cfg_accept),
      .issue     (rd_en),
      .wr_ready  (wr_ready),
      .advance   (advance),
      .s1_valid  (s1_valid),
      .s2_valid  (s2_valid),
      .written   (written)
   );

   always_ff @(posedge clk or negedge async_rst) begin
      if (!async_rst) begin
         state        <= IDLE;
         cfg_ready    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         act_sync_rst <= 1'b0;
         sel_q        <= ACT_RELU;
         rows_q       <= '0;
         src_q        <= '0;
         dst_q        <= '0;
         issued       <= '0;
      end else begin
         done         <= 1'b0;
         act_sync_rst <= 1'b0;
         case (state)
            IDLE: begin
               cfg_ready <= 1'b1;
               if (cfg_accept) begin
                  rows_q <= cfg_rows;
                  src_q  <= cfg_src_base;
                  dst_q  <= cfg_dst_base;
                  issued <= '0;
                  if (cfg_rows == '0) begin
                     done <= 1'b1;
                  end else begin
                     state        <= CLEAR;
                     cfg_ready    <= 1'b0;
                     busy         <= 1'b1;
                     act_sync_rst <= 1'b1;
                     sel_q        <= act_sel_e'(cfg_sel);
                  end
               end
            end
            CLEAR: state <= RUN;
            RUN: begin
               if (rd_en) begin
                  issued <= issued + 1'b1;
                  if (issued == rows_q - 1'b1)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (last_write) begin
                  state     <= IDLE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  cfg_ready <= 1'b1;
                  sel_q     <= ACT_RELU;
               end
            end
            default: state <= IDLE;
         endcase
         if (abort_hit) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_ready <= 1'b1;
            sel_q     <= ACT_RELU;
         end
      end
   end

`ifdef ACT_SEQ_PERF_EN
   always_ff @(posedge clk or negedge async_rst) begin
      if (!async_rst) begin
         stall_cycles <= '0;
         job_cycles   <= '0;
      end else if (cfg_accept) begin
         stall_cycles <= '0;
         job_cycles   <= '0;
      end else begin
         if (s2_valid && !wr_ready && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
         if (busy && job_cycles != '1)
            job_cycles <= job_cycles + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_activation_sequencer.sv
// tb/tb_activation_sequencer.sv - scoreboard bench for activation_sequencer
module tb_activation_sequencer;

   logic       clk = 1'b0;
   logic       async_rst = 1'b0;
   logic       abort = 1'b0;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [1:0] cfg_sel = 2'd0;
   logic [8:0] cfg_rows = 9'd0;
   logic [7:0] cfg_src_base = 8'd0;
   logic [7:0] cfg_dst_base = 8'd0;
   logic       rd_en;
   logic [7:0] rd_addr;
   logic       act_en;
   logic       act_sync_rst;
   logic [1:0] act_sel;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic       wr_ready = 1'b1;
   logic       busy;
   logic       done;
`ifdef ACT_SEQ_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] job_cycles;
`endif

   activation_sequencer dut (
      .clk          (clk),
      .async_rst    (async_rst),
      .abort        (abort),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_sel      (cfg_sel),
      .cfg_rows     (cfg_rows),
      .cfg_src_base (cfg_src_base),
      .cfg_dst_base (cfg_dst_base),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .act_en       (act_en),
      .act_sync_rst (act_sync_rst),
      .act_sel      (act_sel),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_ready     (wr_ready),
      .busy         (busy),
      .done         (done)
`ifdef ACT_SEQ_PERF_EN
      ,
      .stall_cycles (stall_cycles),
      .job_cycles   (job_cycles)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] outs();
      return {7'd0, rd_en, act_en, act_sync_rst, act_sel, wr_en, busy, done, cfg_ready, rd_addr, wr_addr};
   endfunction

   int         cyc = 0;
   logic [7:0] exp_rd[$];
   logic [7:0] exp_wr[$];
   int         rd_cyc[$];
   int         n_rd, n_act, n_wr, n_sync, n_done;
   int         last_rd_cyc, last_wr_cyc, r_cyc;
   bit         lat_chk = 1'b0;
   bit         held_v = 1'b0;
   logic [7:0] held_addr;
   logic [1:0] exp_sel = 2'd0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (async_rst) begin
         if (busy) check("act_sel", act_sel, exp_sel);
         if (rd_en) begin
            n_rd++;
            if (lat_chk && n_rd > 1) check("rd_b2b", cyc - last_rd_cyc, 1);
            last_rd_cyc = cyc;
            rd_cyc.push_back(cyc);
            if (exp_rd.size() == 0) check("rd_unexpected", rd_en, 0);
            else check("rd_addr", rd_addr, exp_rd.pop_front());
         end
         if (act_en) n_act++;
         if (act_sync_rst) n_sync++;
         if (done) begin
            n_done++;
            if (lat_chk) check("done_lat", cyc - last_wr_cyc, 1);
         end
         if (wr_en && !wr_ready) begin
            check("stall_rd_en", rd_en, 0);
            check("stall_act_en", act_en, 0);
            if (held_v) check("wr_hold", wr_addr, held_addr);
            held_v    = 1'b1;
            held_addr = wr_addr;
         end else begin
            held_v = 1'b0;
         end
         if (wr_en && wr_ready) begin
            n_wr++;
            last_wr_cyc = cyc;
            if (exp_wr.size() == 0) check("wr_unexpected", wr_en, 0);
            else check("wr_addr", wr_addr, exp_wr.pop_front());
            if (rd_cyc.size() > 0) begin
               r_cyc = rd_cyc.pop_front();
               if (lat_chk) check("wr_lat", cyc - r_cyc, 2);
            end
         end
      end
   end

   task automatic prep(input logic [7:0] src, input logic [7:0] dst, input int nr, input int nw);
      exp_rd.delete();
      exp_wr.delete();
      rd_cyc.delete();
      n_rd = 0; n_act = 0; n_wr = 0; n_sync = 0; n_done = 0;
      for (int i = 0; i < nr; i++) exp_rd.push_back(8'(src + 8'(i)));
      for (int i = 0; i < nw; i++) exp_wr.push_back(8'(dst + 8'(i)));
   endtask

   task automatic send_cfg(input logic [1:0] sel, input logic [8:0] rows,
                           input logic [7:0] src, input logic [7:0] dst);
      exp_sel      = sel;
      cfg_sel      = sel;
      cfg_rows     = rows;
      cfg_src_base = src;
      cfg_dst_base = dst;
      cfg_valid    = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cfg_ready) break;
      end
      check("cfg_ready_wait", cfg_ready, 1);
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) break;
      end
      check("done_seen", done, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic end_checks(input int er, input int ea, input int es, input int ew, input int ed);
      check("n_rd", n_rd, er);
      check("n_act", n_act, ea);
      check("n_sync", n_sync, es);
      check("n_wr", n_wr, ew);
      check("n_done", n_done, ed);
      check("rd_left", exp_rd.size(), 0);
      check("wr_left", exp_wr.size(), 0);
   endtask

   initial begin
      #12;
      check("rst_outs", outs(), 0);
      @(posedge clk); #1;
      async_rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rdy_after_rst", cfg_ready, 1);
      @(posedge clk); #1;

      // basic job, full throughput
      prep(8'h10, 8'h20, 4, 4);
      lat_chk = 1'b1;
      send_cfg(2'd0, 9'd4, 8'h10, 8'h20);
      wait_done();
      lat_chk = 1'b0;
      end_checks(4, 5, 1, 4, 1);

      // write stall on the second row
      prep(8'h00, 8'h08, 3, 3);
      send_cfg(2'd1, 9'd3, 8'h00, 8'h08);
      repeat (4) @(posedge clk);
      #1;
      wr_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      wr_ready = 1'b1;
      wait_done();
      end_checks(3, 4, 1, 3, 1);

      // empty job
      prep(8'h00, 8'h00, 0, 0);
      send_cfg(2'd2, 9'd0, 8'h44, 8'h55);
      @(negedge clk);
      check("done_rows0", done, 1);
      check("busy_rows0", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      end_checks(0, 0, 0, 0, 1);

      // source address wrap
      prep(8'hFE, 8'h80, 4, 4);
      send_cfg(2'd3, 9'd4, 8'hFE, 8'h80);
      wait_done();
      end_checks(4, 5, 1, 4, 1);

      // abort in third RUN cycle, then a normal job
      prep(8'h40, 8'h50, 3, 1);
      send_cfg(2'd2, 9'd8, 8'h40, 8'h50);
      repeat (3) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_idle", {busy, cfg_ready, rd_en, act_en, wr_en}, 5'b01000);
      repeat (4) @(posedge clk);
      #1;
      end_checks(3, 3, 1, 1, 0);
      prep(8'h60, 8'h70, 2, 2);
      send_cfg(2'd1, 9'd2, 8'h60, 8'h70);
      wait_done();
      end_checks(2, 3, 1, 2, 1);

      // asynchronous reset during DRAIN
      prep(8'h30, 8'h38, 3, 1);
      send_cfg(2'd1, 9'd3, 8'h30, 8'h38);
      repeat (4) @(posedge clk);
      #1;
      check("pre_rst_busy", busy, 1);
      async_rst = 1'b0;
      #1;
      check("rst_mid_outs", outs(), 0);
      @(posedge clk); #1;
      async_rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rdy_after_mid_rst", cfg_ready, 1);
      end_checks(3, 3, 1, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
